bemf_pwm_sequencer: RTL and testbench

Upstream stage of the per-axis MotorLogic instances. Generates the 4 PWM waveforms and 2-bit direction controls from bus-written registers, and periodically opens a back-EMF measurement window: coasts all axes, waits a settle time, then handshakes one sample request with the ADC sampler. Sits on the same local bus decode as the other peripherals and raises one interrupt source into the primary interrupt mux.

---
 rtl/bemf_pwm_sequencer_pkg.sv | 24 ++
 rtl/bemf_pwm_sequencer_if.sv | 14 +
 rtl/bemf_pwm_sequencer_pwm_channel.sv | 25 ++
 rtl/bemf_pwm_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_bemf_pwm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bemf_pwm_sequencer_pkg.sv
// Shared definitions for the back-EMF PWM sequencer: sequencer states,
// register map indices and Status bit positions.
package bemf_pwm_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } seqState_t;

  localparam logic [2:0] REG_DUTY0   = 3'd0;
  localparam logic [2:0] REG_DUTY1   = 3'd1;
  localparam logic [2:0] REG_DUTY2   = 3'd2;
  localparam logic [2:0] REG_DUTY3   = 3'd3;
  localparam logic [2:0] REG_CONTROL = 3'd4;
  localparam logic [2:0] REG_MEAS    = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;
  localparam logic [2:0] REG_FRAME   = 3'd7;

  localparam int STAT_BUSY = 0;
  localparam int STAT_TERR = 1;
  localparam int STAT_INT  = 2;

endpackage

// File: rtl/bemf_pwm_sequencer_if.sv
// Local-bus register port of the sequencer; the bus decoder drives the master side.
interface bemf_pwm_sequencer_if;

  logic [2:0]  Addr;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        En;
  logic        Rd;
  logic        Wr;

  modport master (output Addr, DataWr, En, Rd, Wr, input DataRd);
  modport slave  (input Addr, DataWr, En, Rd, Wr, output DataRd);

endinterface

// File: rtl/bemf_pwm_sequencer_pwm_channel.sv
// One PWM axis: duty is shadowed at frame end so a mid-frame write never
// produces a runt pulse, then compared against the shared frame counter.
module bemf_pwm_sequencer_pwm_channel (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic [7:0] duty,
  input  logic       frameEnd,
  input  logic       enable,
  input  logic [7:0] pwmCnt,
  output logic       pwmOut
);

  logic [7:0] dutyShadow;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      dutyShadow <= '0;
      pwmOut     <= 1'b0;
    end else begin
      if (frameEnd) dutyShadow <= duty;
      pwmOut <= enable && (pwmCnt < dutyShadow);
    end
  end

endmodule

// File: rtl/bemf_pwm_sequencer.sv
// Four-axis PWM generator that periodically coasts all axes, lets the
// back-EMF settle and then handshakes one sample request with the ADC.
module bemf_pwm_sequencer #(
  parameter int PRESCALE       = 4,
  parameter int SAMPLE_TIMEOUT = 1024
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  bemf_pwm_sequencer_if.slave        bus,
  output logic [3:0]                 PwmOut,
  output logic [7:0]                 PwmCont,
  output logic [3:0]                 AxisActive,
  output logic [3:0]                 AxisMeasure,
  output logic                       SampleReq,
  input  logic                       SampleAck,
  output logic                       IntStatus,
  input  logic                       IntReset
);

  import bemf_pwm_sequencer_pkg::*;

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TO_W  = (SAMPLE_TIMEOUT > 1) ? $clog2(SAMPLE_TIMEOUT) : 1;

  logic [PRE_W-1:0] presCnt;
  logic             tick;
  logic [7:0]       pwmCnt;
  logic             frameEnd;
  logic             pwmEnable;
  logic [7:0]       duty [4];
  logic [7:0]       controlReg;
  logic [7:0]       measPeriod;
  logic [7:0]       settle;
  logic [15:0]      frameCount;
  logic             timeoutErr;
  seqState_t        state;
  logic [7:0]       measCnt;
  logic [7:0]       settleCnt;
  logic [7:0]       settleLatch;
  logic [TO_W-1:0]  toCnt;
  logic             wrEn;
  logic             busy;
  logic [15:0]      statusWord;

  assign tick      = (presCnt == PRE_W'(PRESCALE - 1));
  assign frameEnd  = (state == RUN) && tick && (pwmCnt == 8'hFF);
  assign pwmEnable = (state == RUN);
  assign busy      = (state != RUN);
  assign wrEn      = bus.En && bus.Wr;
  assign PwmCont   = controlReg;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) presCnt <= '0;
    else         presCnt <= tick ? '0 : presCnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 4; i++) duty[i] <= '0;
      controlReg <= '0;
      measPeriod <= '0;
      settle     <= '0;
    end else if (wrEn) begin
      case (bus.Addr)
        REG_DUTY0:   duty[0]    <= bus.DataWr[7:0];
        REG_DUTY1:   duty[1]    <= bus.DataWr[7:0];
        REG_DUTY2:   duty[2]    <= bus.DataWr[7:0];
        REG_DUTY3:   duty[3]    <= bus.DataWr[7:0];
        REG_CONTROL: controlReg <= bus.DataWr[7:0];
        REG_MEAS: begin
          measPeriod <= bus.DataWr[7:0];
          settle     <= bus.DataWr[15:8];
        end
        default: ;
      endcase
    end
  end

  // Sticky flags are cleared first so a same-cycle set further down wins.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= RUN;
      pwmCnt      <= '0;
      frameCount  <= '0;
      measCnt     <= '0;
      settleCnt   <= '0;
      settleLatch <= '0;
      toCnt       <= '0;
      AxisActive  <= 4'hF;
      AxisMeasure <= 4'h0;
      SampleReq   <= 1'b0;
      IntStatus   <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      if (IntReset) IntStatus <= 1'b0;
      if (wrEn && (bus.Addr == REG_STATUS) && bus.DataWr[STAT_TERR]) timeoutErr <= 1'b0;

      case (state)
        RUN: begin
          if (tick) pwmCnt <= pwmCnt + 8'd1;
          if (measPeriod == 8'd0) measCnt <= '0;
          if (frameEnd) begin
            frameCount <= frameCount + 16'd1;
            if (measPeriod != 8'd0) begin
              if (measCnt + 8'd1 == measPeriod) begin
                measCnt     <= '0;
                settleCnt   <= '0;
                settleLatch <= settle;
                AxisActive  <= 4'h0;
                state       <= SETTLE;
              end else begin
                measCnt <= measCnt + 8'd1;
              end
            end
          end
        end

        // Settle time is latched on entry so a rewrite only affects the next window.
        SETTLE: begin
          pwmCnt <= '0;
          if ((settleLatch == 8'd0) || (tick && (settleCnt + 8'd1 == settleLatch))) begin
            toCnt       <= '0;
            SampleReq   <= 1'b1;
            AxisMeasure <= 4'hF;
            state       <= SAMPLE;
          end else if (tick) begin
            settleCnt <= settleCnt + 8'd1;
          end
        end

        SAMPLE: begin
          pwmCnt <= '0;
          if (SampleAck || (toCnt == TO_W'(SAMPLE_TIMEOUT - 1))) begin
            SampleReq   <= 1'b0;
            AxisMeasure <= 4'h0;
            AxisActive  <= 4'hF;
            state       <= RUN;
            if (SampleAck) IntStatus  <= 1'b1;
            else           timeoutErr <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    statusWord            = '0;
    statusWord[STAT_BUSY] = busy;
    statusWord[STAT_TERR] = timeoutErr;
    statusWord[STAT_INT]  = IntStatus;
  end

  always_comb begin
    bus.DataRd = '0;
    if (bus.En && bus.Rd) begin
      case (bus.Addr)
        REG_DUTY0:   bus.DataRd = {8'h00, duty[0]};
        REG_DUTY1:   bus.DataRd = {8'h00, duty[1]};
        REG_DUTY2:   bus.DataRd = {8'h00, duty[2]};
        REG_DUTY3:   bus.DataRd = {8'h00, duty[3]};
        REG_CONTROL: bus.DataRd = {8'h00, controlReg};
        REG_MEAS:    bus.DataRd = {settle, measPeriod};
        REG_STATUS:  bus.DataRd = statusWord;
        REG_FRAME:   bus.DataRd = frameCount;
        default:     bus.DataRd = '0;
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : gChan
    bemf_pwm_sequencer_pwm_channel uChan (
      .Clk      (Clk),
      .ResetN   (ResetN),
      .duty     (duty[i]),
      .frameEnd (frameEnd),
      .enable   (pwmEnable),
      .pwmCnt   (pwmCnt),
      .pwmOut   (PwmOut[i])
    );
  end

endmodule

// File: tb/tb_bemf_pwm_sequencer.sv
// Randomized bench for the back-EMF PWM sequencer; expectations come from
// duty/period arithmetic and a register shadow rather than cycle-level state.
module tb_bemf_pwm_sequencer;

  import bemf_pwm_sequencer_pkg::*;

  localparam int PRESCALE       = 4;
  localparam int SAMPLE_TIMEOUT = 1024;
  localparam int FRAME_CLKS     = 256 * PRESCALE;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic [3:0] PwmOut;
  logic [7:0] PwmCont;
  logic [3:0] AxisActive;
  logic [3:0] AxisMeasure;
  logic       SampleReq;
  logic       SampleAck;
  logic       IntStatus;
  logic       IntReset;

  int total = 0;
  int bad   = 0;

  logic [15:0] expReg [8];
  logic [15:0] rd;
  logic [15:0] f0;
  logic [7:0]  dutyVal [4];
  int          hi [4];

  bemf_pwm_sequencer_if bus ();

  bemf_pwm_sequencer #(
    .PRESCALE       (PRESCALE),
    .SAMPLE_TIMEOUT (SAMPLE_TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .bus         (bus),
    .PwmOut      (PwmOut),
    .PwmCont     (PwmCont),
    .AxisActive  (AxisActive),
    .AxisMeasure (AxisMeasure),
    .SampleReq   (SampleReq),
    .SampleAck   (SampleAck),
    .IntStatus   (IntStatus),
    .IntReset    (IntReset)
  );

  always #5 Clk = ~Clk;

  // Measures coast-window and request lengths and flags inconsistent axis outputs.
  int curLow = 0, lastLow = 0, curReq = 0, lastReq = 0, measViol = 0, activeDrops = 0;
  always @(negedge Clk) begin
    if (!ResetN) begin
      curLow = 0;
      curReq = 0;
    end else begin
      if (AxisActive != 4'hF) activeDrops++;
      if (AxisActive == 4'h0) curLow++;
      else if (curLow != 0) begin lastLow = curLow; curLow = 0; end
      if (SampleReq) curReq++;
      else if (curReq != 0) begin lastReq = curReq; curReq = 0; end
      if (AxisActive == 4'h0 && PwmOut != 4'h0) measViol++;
      if (AxisActive != 4'h0 && AxisActive != 4'hF) measViol++;
      if (AxisMeasure !== (SampleReq ? 4'hF : 4'h0)) measViol++;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [15:0] data);
    @(negedge Clk);
    bus.Addr   = addr;
    bus.DataWr = data;
    bus.En     = 1'b1;
    bus.Wr     = 1'b1;
    @(negedge Clk);
    bus.En = 1'b0;
    bus.Wr = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] addr, output logic [15:0] data);
    bus.Addr = addr;
    bus.En   = 1'b1;
    bus.Rd   = 1'b1;
    #1 data = bus.DataRd;
    bus.En = 1'b0;
    bus.Rd = 1'b0;
  endtask

  task automatic waitActive(input logic [3:0] value, input int budget, input string tag);
    int n = 0;
    while (AxisActive !== value && n < budget) begin @(negedge Clk); n++; end
    checkOutput(tag, 32'(AxisActive), 32'(value));
  endtask

  task automatic waitReq(input logic value, input int budget, input string tag);
    int n = 0;
    while (SampleReq !== value && n < budget) begin @(negedge Clk); n++; end
    checkOutput(tag, 32'(SampleReq), 32'(value));
  endtask

  task automatic countWindow(input bit atSample, input bit doWrite, input logic [7:0] wData,
                             output int highCnt, output int firstLow);
    highCnt  = 0;
    firstLow = -1;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      if (i > 0 || !atSample) @(negedge Clk);
      if (PwmOut[0]) highCnt++;
      else if (firstLow < 0) firstLow = i;
      if (doWrite && i == 100) begin
        bus.Addr   = REG_DUTY0;
        bus.DataWr = {8'h00, wData};
        bus.En     = 1'b1;
        bus.Wr     = 1'b1;
      end
      if (doWrite && i == 101) begin
        bus.En = 1'b0;
        bus.Wr = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus();
    int p, s, d, violBefore, highCnt, firstLow, found;
    logic prev;

    // Reset values, sampled while reset is still held.
    ResetN = 1'b1; SampleAck = 1'b0; IntReset = 1'b0;
    bus.Addr = '0; bus.DataWr = '0; bus.En = 1'b0; bus.Rd = 1'b0; bus.Wr = 1'b0;
    #2 ResetN = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset AxisActive", 32'(AxisActive), 32'h0F);
    checkOutput("reset SampleReq", 32'(SampleReq), 32'h0);
    checkOutput("reset PwmOut", 32'(PwmOut), 32'h0);
    checkOutput("reset PwmCont", 32'(PwmCont), 32'h0);
    checkOutput("reset AxisMeasure", 32'(AxisMeasure), 32'h0);
    checkOutput("reset IntStatus", 32'(IntStatus), 32'h0);
    @(negedge Clk) ResetN = 1'b1;
    for (int a = 0; a < 8; a++) begin
      busRead(3'(a), rd);
      checkOutput($sformatf("reset reg%0d", a), 32'(rd), 32'h0);
    end

    // Register readback against a shadow model; MeasPeriod kept 0.
    for (int a = 0; a < 6; a++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (a == 5) w[7:0] = 8'h00;
      expReg[a] = (a == 5) ? w : (w & 16'h00FF);
      busWrite(3'(a), w);
    end
    for (int a = 0; a < 6; a++) begin
      busRead(3'(a), rd);
      checkOutput($sformatf("readback reg%0d", a), 32'(rd), 32'(expReg[a]));
    end
    checkOutput("PwmCont follows Control", 32'(PwmCont), 32'(expReg[4][7:0]));
    bus.Addr = REG_CONTROL; bus.En = 1'b1; bus.Rd = 1'b0;
    #1 checkOutput("DataRd idle", 32'(bus.DataRd), 32'h0);
    bus.En = 1'b0;

    // Duty cycle: any 1024-clock window of a stable frame holds duty*PRESCALE high clocks.
    for (int it = 0; it < 2; it++) begin
      for (int ch = 0; ch < 4; ch++) begin
        dutyVal[ch] = 8'($urandom);
        if (it == 0 && ch == 0) dutyVal[ch] = 8'd64;
        if (it == 1 && ch == 0) dutyVal[ch] = 8'd0;
        if (it == 1 && ch == 1) dutyVal[ch] = 8'd255;
        busWrite(3'(ch), {8'h00, dutyVal[ch]});
      end
      repeat (FRAME_CLKS + 8) @(negedge Clk);
      for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
      repeat (FRAME_CLKS) begin
        @(negedge Clk);
        for (int ch = 0; ch < 4; ch++) if (PwmOut[ch]) hi[ch]++;
      end
      for (int ch = 0; ch < 4; ch++)
        checkOutput($sformatf("duty ch%0d it%0d", ch, it), 32'(hi[ch]), 32'(dutyVal[ch]) * PRESCALE);
    end
    checkOutput("AxisActive held during pwm", 32'(activeDrops), 32'h0);

    // Mid-frame duty writes only take effect at the following frame.
    busWrite(REG_DUTY0, 16'd128);
    repeat (FRAME_CLKS + 8) @(negedge Clk);
    prev = PwmOut[0];
    found = 0;
    for (int n = 0; n < FRAME_CLKS + 16 && found == 0; n++) begin
      @(negedge Clk);
      if (PwmOut[0] && !prev) found = 1;
      prev = PwmOut[0];
    end
    checkOutput("pwm0 frame start", 32'(found), 32'h1);
    countWindow(1'b1, 1'b1, 8'd0, highCnt, firstLow);
    checkOutput("old duty kept high", 32'(highCnt), 32'd512);
    countWindow(1'b0, 1'b1, 8'd255, highCnt, firstLow);
    checkOutput("duty 0 high", 32'(highCnt), 32'd0);
    countWindow(1'b0, 1'b0, 8'd0, highCnt, firstLow);
    checkOutput("duty 255 high", 32'(highCnt), 32'd1020);
    checkOutput("duty 255 low slot", 32'(firstLow), 32'd1020);

    // An ack outside SAMPLE must not raise the interrupt.
    @(negedge Clk) SampleAck = 1'b1;
    @(negedge Clk) SampleAck = 1'b0;
    #1 checkOutput("ack in RUN ignored", 32'(IntStatus), 32'h0);

    // Measurement windows: coast = settle ticks (or 1 clk) + ack delay.
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(2, 1);
      s = (it == 0) ? 3 : $urandom_range(4, 1);
      d = (it == 0) ? 5 : $urandom_range(8, 1);
      if (it == 0) p = 2;
      if (it == 2) s = 0;
      violBefore = measViol;
      busWrite(REG_MEAS, {8'(s), 8'(p)});
      busRead(REG_FRAME, f0);
      waitActive(4'h0, p * FRAME_CLKS + 64, "settle entry");
      busRead(REG_FRAME, rd);
      checkOutput("frame count at entry", 32'(rd), 32'(f0 + 16'(p)));
      busRead(REG_STATUS, rd);
      checkOutput("status busy", 32'(rd), 32'h0001);
      waitReq(1'b1, 4 * s + 8, "sample request");
      repeat (d - 1) @(negedge Clk);
      SampleAck = 1'b1;
      IntReset  = 1'b1;
      @(negedge Clk);
      SampleAck = 1'b0;
      IntReset  = 1'b0;
      #1;
      checkOutput("int set beats clear", 32'(IntStatus), 32'h1);
      checkOutput("coast length", 32'(lastLow), 32'(((s == 0) ? 1 : 4 * s) + d));
      checkOutput("request length", 32'(lastReq), 32'(d));
      busWrite(REG_MEAS, 16'h0000);
      busRead(REG_STATUS, rd);
      checkOutput("status after ack", 32'(rd), 32'h0004);
      @(negedge Clk) IntReset = 1'b1;
      @(negedge Clk) IntReset = 1'b0;
      #1 checkOutput("int cleared", 32'(IntStatus), 32'h0);
      checkOutput("axis outputs during meas", 32'(measViol - violBefore), 32'h0);
    end

    // Unanswered request aborts after SAMPLE_TIMEOUT clocks.
    busWrite(REG_MEAS, {8'd2, 8'd1});
    waitActive(4'h0, FRAME_CLKS + 64, "timeout settle entry");
    waitReq(1'b1, 16, "timeout request");
    waitReq(1'b0, SAMPLE_TIMEOUT + 16, "timeout release");
    #1 checkOutput("timeout request length", 32'(lastReq), 32'(SAMPLE_TIMEOUT));
    checkOutput("timeout AxisActive", 32'(AxisActive), 32'h0F);
    busWrite(REG_MEAS, 16'h0000);
    busRead(REG_STATUS, rd);
    checkOutput("status timeout", 32'(rd), 32'h0002);
    busWrite(REG_STATUS, 16'h0002);
    busRead(REG_STATUS, rd);
    checkOutput("timeout w1c", 32'(rd), 32'h0000);

    // Asynchronous reset in the middle of SAMPLE.
    busWrite(REG_CONTROL, 16'h00A5);
    checkOutput("PwmCont A5", 32'(PwmCont), 32'hA5);
    busWrite(REG_MEAS, {8'd0, 8'd1});
    waitReq(1'b1, FRAME_CLKS + 64, "reset test request");
    #2 ResetN = 1'b0;
    #1;
    checkOutput("async SampleReq", 32'(SampleReq), 32'h0);
    checkOutput("async AxisActive", 32'(AxisActive), 32'h0F);
    checkOutput("async PwmCont", 32'(PwmCont), 32'h0);
    checkOutput("async AxisMeasure", 32'(AxisMeasure), 32'h0);
    @(negedge Clk) ResetN = 1'b1;
    busRead(REG_MEAS, rd);
    checkOutput("meas reg after reset", 32'(rd), 32'h0);
    busRead(REG_STATUS, rd);
    checkOutput("status after reset", 32'(rd), 32'h0);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
